// File: rtl/utest_monitor.sv
// Microcode checkpoint monitor: PASS/LOOP/FAIL/END label table on retire.
// Optional watchdog: define UTEST_MONITOR_WATCHDOG_EN.
module utest_monitor #(
  parameter int NLABELS  = 8,
  parameter int PC_W     = 12,
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 1000,
  localparam int IW = (NLABELS > 1) ? $clog2(NLABELS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               retire,
  input  logic [PC_W-1:0]    pc_x,
  input  logic [3:0]         sqi,
  input  logic [1:0]         map,
  input  logic [PC_W-1:0]    a,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [1:0]         cfg_kind,
  input  logic [PC_W-1:0]    cfg_label,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic               hit,
  output logic [IW-1:0]      hit_idx,
  output logic               jump_req,
  output logic [PC_W-1:0]    jump_addr,
  output logic [NLABELS-1:0] pass_mask,
  output logic               done,
  output logic               fail,
  output logic [1:0]         fail_code,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE, S_FAIL
  } state_t;

  localparam logic [1:0] K_PASS = 2'd0;
  localparam logic [1:0] K_LOOP = 2'd1;
  localparam logic [1:0] K_FAIL = 2'd2;
  localparam logic [1:0] K_END  = 2'd3;

  state_t             state;
  logic [NLABELS-1:0] vld;
  logic [1:0]         kind    [NLABELS];
  logic [PC_W-1:0]    lbl     [NLABELS];
  logic [CNT_W-1:0]   cnt_max [NLABELS];
  logic [CNT_W-1:0]   lcnt    [NLABELS];

  logic          cont;
  logic          f_any;
  logic          e_any;
  logic          p_any;
  logic [IW-1:0] p_idx;
  logic [CNT_W-1:0] p_cnt;
  logic          p_jump;

`ifdef UTEST_MONITOR_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // descending scan so the lowest matching PASS/LOOP index wins
  always_comb begin
    cont  = (sqi == 4'd14) && (map == 2'd0);
    f_any = 1'b0;
    e_any = 1'b0;
    p_any = 1'b0;
    p_idx = '0;
    for (int i = NLABELS - 1; i >= 0; i--) begin
      if (vld[i] && kind[i] == K_FAIL && pc_x == lbl[i])
        f_any = 1'b1;
      if (vld[i] && kind[i] == K_END && pc_x == lbl[i])
        e_any = 1'b1;
      if (vld[i] && (kind[i] == K_PASS || kind[i] == K_LOOP)
          && cont && a == lbl[i]) begin
        p_any = 1'b1;
        p_idx = IW'(i);
      end
    end
    p_cnt  = lcnt[p_idx] + 1'b1;
    p_jump = (kind[p_idx] == K_LOOP) && (p_cnt < cnt_max[p_idx]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      vld         <= '0;
      hit         <= 1'b0;
      hit_idx     <= '0;
      jump_req    <= 1'b0;
      jump_addr   <= '0;
      pass_mask   <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      retired_cnt <= '0;
      for (int i = 0; i < NLABELS; i++) begin
        kind[i]    <= K_PASS;
        lbl[i]     <= '0;
        cnt_max[i] <= '0;
        lcnt[i]    <= '0;
      end
`ifdef UTEST_MONITOR_WATCHDOG_EN
      wd_cnt <= '0;
`endif
    end else begin
      hit      <= 1'b0;
      jump_req <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_we && int'(cfg_idx) < NLABELS) begin
            vld[cfg_idx]       <= 1'b1;
            kind[cfg_idx]      <= cfg_kind;
            lbl[cfg_idx]       <= cfg_label;
            cnt_max[cfg_idx]   <= cfg_count;
            lcnt[cfg_idx]      <= '0;
            pass_mask[cfg_idx] <= 1'b0;
          end
          if (arm)
            state <= S_RUN;
`ifdef UTEST_MONITOR_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (retire) begin
            if (retired_cnt != '1)
              retired_cnt <= retired_cnt + 1'b1;
            if (f_any) begin
              state     <= S_FAIL;
              fail      <= 1'b1;
              fail_code <= 2'd1;
            end else if (e_any) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (p_any) begin
              if (p_jump) begin
                jump_req    <= 1'b1;
                jump_addr   <= lbl[p_idx];
                lcnt[p_idx] <= p_cnt;
              end else begin
                hit              <= 1'b1;
                hit_idx          <= p_idx;
                pass_mask[p_idx] <= 1'b1;
                lcnt[p_idx]      <= '0;
              end
            end
          end
`ifdef UTEST_MONITOR_WATCHDOG_EN
          if (retire) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            fail_code <= 2'd2;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_DONE: ;
        S_FAIL: ;
      endcase
    end
  end

endmodule

// File: tb/tb_utest_monitor.sv
// Directed bench for utest_monitor: PASS, LOOP, FAIL, END, reset, watchdog.
// Watchdog checks follow UTEST_MONITOR_WATCHDOG_EN.
module tb_utest_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        retire = 1'b0;
  logic [11:0] pc_x = '0;
  logic [3:0]  sqi = '0;
  logic [1:0]  map = '0;
  logic [11:0] a = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [1:0]  cfg_kind = '0;
  logic [11:0] cfg_label = '0;
  logic [15:0] cfg_count = '0;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        jump_req;
  logic [11:0] jump_addr;
  logic [7:0]  pass_mask;
  logic        done;
  logic        fail;
  logic [1:0]  fail_code;
  logic [15:0] retired_cnt;

  int total = 0;
  int bad = 0;
  int nj, nh;
  logic [2:0] lidx;

  utest_monitor #(
    .NLABELS(8), .PC_W(12), .CNT_W(16), .WD_LIMIT(10)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .retire(retire), .pc_x(pc_x), .sqi(sqi),
    .map(map), .a(a), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_kind(cfg_kind),
    .cfg_label(cfg_label), .cfg_count(cfg_count),
    .hit(hit), .hit_idx(hit_idx),
    .jump_req(jump_req), .jump_addr(jump_addr),
    .pass_mask(pass_mask), .done(done),
    .fail(fail), .fail_code(fail_code),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [1:0] k,
                     input logic [11:0] l, input logic [15:0] c);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_kind = k;
    cfg_label = l;
    cfg_count = c;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm_it();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic ret(input logic [11:0] pc, input logic [3:0] s,
                     input logic [1:0] m, input logic [11:0] ad);
    retire = 1'b1;
    pc_x = pc;
    sqi = s;
    map = m;
    a = ad;
    tick();
    retire = 1'b0;
  endtask

  task automatic cont(input logic [11:0] ad);
    ret(12'd100, 4'd14, 2'd0, ad);
  endtask

  task automatic run_loop(input int n, output int j, output int h,
                          output logic [2:0] li);
    j = 0;
    h = 0;
    li = '0;
    for (int k = 0; k < n; k++) begin
      cont(12'd477);
      if (jump_req && jump_addr == 12'd477) j++;
      if (hit) begin
        h++;
        li = hit_idx;
      end
    end
  endtask

  initial begin
    do_reset();
    chk("rst_hit", hit, 0);
    chk("rst_jump", jump_req, 0);
    chk("rst_mask", pass_mask, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_rcnt", retired_cnt, 0);

    // PASS, with same-cycle arm+retire ignored
    cfg(3'd0, 2'd0, 12'd30, 16'd1);
    arm = 1'b1;
    cont(12'd30);
    arm = 1'b0;
    chk("arm_ret_hit", hit, 0);
    chk("arm_ret_rcnt", retired_cnt, 0);
    cont(12'd30);
    chk("pass_hit", hit, 1);
    chk("pass_idx", hit_idx, 0);
    chk("pass_mask", pass_mask, 8'h01);
    chk("pass_rcnt", retired_cnt, 1);
    tick();
    chk("pass_pulse", hit, 0);
    ret(12'd100, 4'd13, 2'd0, 12'd30);
    chk("pass_sqi13", hit, 0);

    // LOOP count 1 behaves as PASS, then LOOP 256
    do_reset();
    cfg(3'd3, 2'd1, 12'd40, 16'd1);
    cfg(3'd2, 2'd1, 12'd477, 16'd256);
    arm_it();
    cont(12'd40);
    chk("loop1_hit", hit, 1);
    chk("loop1_idx", hit_idx, 3);
    chk("loop1_jump", jump_req, 0);
    run_loop(256, nj, nh, lidx);
    chk("loop_jumps", nj, 255);
    chk("loop_hits", nh, 1);
    chk("loop_idx", lidx, 2);
    chk("loop_mask", pass_mask, 8'h0c);
    cont(12'd477);
    chk("loop_restart", jump_req, 1);
    chk("loop_rcnt", retired_cnt, 258);

    // FAIL beats PASS on same retire
    do_reset();
    cfg(3'd0, 2'd2, 12'd1278, 16'd1);
    cfg(3'd1, 2'd0, 12'd1278, 16'd1);
    arm_it();
    ret(12'd1278, 4'd14, 2'd0, 12'd1278);
    chk("fl_fail", fail, 1);
    chk("fl_code", fail_code, 1);
    chk("fl_hit", hit, 0);
    chk("fl_mask", pass_mask, 0);
    cont(12'd1278);
    chk("fl_after_hit", hit, 0);
    chk("fl_hold", fail, 1);

    // three passes, priority on duplicate label, then END
    do_reset();
    cfg(3'd0, 2'd0, 12'd10, 16'd1);
    cfg(3'd1, 2'd0, 12'd11, 16'd1);
    cfg(3'd2, 2'd0, 12'd12, 16'd1);
    cfg(3'd5, 2'd0, 12'd12, 16'd1);
    cfg(3'd3, 2'd3, 12'd1273, 16'd1);
    arm_it();
    cont(12'd10);
    cont(12'd11);
    cont(12'd12);
    chk("dup_idx", hit_idx, 2);
    chk("end_mask3", pass_mask, 8'h07);
    ret(12'd1273, 4'd0, 2'd0, 12'd0);
    chk("end_done", done, 1);
    chk("end_fail", fail, 0);
    chk("end_mask", pass_mask, 8'h07);
    cfg(3'd4, 2'd0, 12'd50, 16'd1);
    cont(12'd50);
    chk("end_cfg_ign", hit, 0);
    chk("end_rcnt", retired_cnt, 4);
    chk("end_hold", done, 1);

    // reset mid-loop
    do_reset();
    cfg(3'd2, 2'd1, 12'd477, 16'd256);
    arm_it();
    run_loop(100, nj, nh, lidx);
    chk("mid_jumps", nj, 100);
    reset = 1'b1;
    #1;
    chk("mid_rst_jump", jump_req, 0);
    chk("mid_rst_rcnt", retired_cnt, 0);
    tick();
    reset = 1'b0;
    arm_it();
    cont(12'd477);
    chk("mid_inval", jump_req, 0);
    do_reset();
    cfg(3'd2, 2'd1, 12'd477, 16'd256);
    arm_it();
    run_loop(256, nj, nh, lidx);
    chk("mid_rejumps", nj, 255);
    chk("mid_rehits", nh, 1);

`ifdef UTEST_MONITOR_WATCHDOG_EN
    do_reset();
    arm_it();
    repeat (9) tick();
    chk("wd_early", fail, 0);
    tick();
    chk("wd_fail", fail, 1);
    chk("wd_code", fail_code, 2);
`else
    do_reset();
    arm_it();
    repeat (20) tick();
    chk("nowd_fail", fail, 0);
    chk("nowd_code", fail_code, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
